lfsr_draw_gen: RTL
==================

Name: lfsr_draw_gen

Overview:
Parameterised Fibonacci LFSR random source with a request/valid draw engine for the spin logic. It advances the LFSR, takes an OUT_BITS-wide sample, and rejects samples that fall outside 0..RANGE-1. After MAX_TRIES rejections it returns a bounded fallback value. It also supports free-running mode, runtime reseeding and lock-up-state protection. It sits between the game FSM and the reel/spin decode logic.

Parameters:
WIDTH, 16, LFSR state width; legal range 3..32.
TAPS, 16'hB400, feedback tap mask; bit i set means state[i] feeds the feedback reduction.
XNOR, 1, 1 = feedback is the inverted XOR reduction (XNOR), 0 = plain XOR reduction.
SEED, 0, reset and substitute state; must not equal the lock state.
OUT_BITS, 4, draw width; legal range 1..WIDTH.
RANGE, 10, accepted draws are 0..RANGE-1; constraint 2*RANGE >= 2^OUT_BITS and RANGE <= 2^OUT_BITS.
MAX_TRIES, 8, number of rejected samples before the fallback value is used; must be >= 1.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
free_run  in  1  when high, LFSR shifts every cycle while the FSM is in IDLE
seed_load  in  1  loads seed_in into the LFSR on the next edge
seed_in  in  WIDTH  seed value
draw_req  in  1  starts a draw; sampled only in IDLE
draw_busy  out  1  high in every state other than IDLE
draw_valid  out  1  one-cycle pulse; draw_value is valid while it is high
draw_value  out  OUT_BITS  result; held until the next draw_valid
draw_fallback  out  1  qualifies draw_valid; 1 = value came from the fallback path
seed_rejected  out  1  one-cycle pulse: seed_in equalled the lock state and SEED was loaded instead
lfsr_state  out  WIDTH  current LFSR state

Behaviour:
- Feedback: fb = ^(state & TAPS), inverted when XNOR=1.
- Shift: state <= {state[WIDTH-2:0], fb}.
- Lock state: all ones when XNOR=1, all zeros when XNOR=0.
- Reset, asynchronous: state=SEED, FSM=IDLE, try counter=0, and draw_busy, draw_valid, draw_fallback, seed_rejected, draw_value all 0.
- Reset asserted mid-draw: the draw is abandoned; no draw_valid is issued.
- FSM states: IDLE, SHIFT, CHECK, DONE.
- IDLE:
  - If draw_req: go to SHIFT; clear shift counter and try counter.
  - Otherwise, if free_run: shift once per cycle.
- SHIFT: shift once per cycle for exactly OUT_BITS cycles, then go to CHECK. free_run is ignored in this state.
- CHECK (no shift); let sample = state[OUT_BITS-1:0]:
  - sample < RANGE: latch draw_value=sample, draw_fallback=0, go to DONE.
  - Otherwise, increment the try counter. If the counter reaches MAX_TRIES: latch draw_value = sample - RANGE (always < RANGE by the parameter constraint), draw_fallback=1, go to DONE. Else return to SHIFT with the shift counter cleared.
- DONE: draw_valid=1 for this cycle only, then go to IDLE. draw_busy is still high in DONE.
- Latency: draw_req sampled at edge k gives draw_valid high in the cycle after edge k+OUT_BITS+1 when the first sample is accepted. Each rejection adds OUT_BITS+1 cycles.
- draw_req while busy: ignored, not queued.
- draw_req in DONE: ignored; a new request is accepted only once the FSM is back in IDLE.
- seed_load has top priority in every state:
  - state <= seed_in, or state <= SEED with a seed_rejected pulse if seed_in equals the lock state.
  - FSM goes to IDLE and counters clear.
  - An in-flight draw is aborted with no draw_valid.
  - draw_req in the same cycle as seed_load is ignored.
- The lock state is unreachable except through seed_in, which is filtered as above; the LFSR never sticks.
- draw_value and draw_fallback change only in the CHECK→DONE transition.

Test Plan:
- Use WIDTH=4, TAPS=4'b1100, XNOR=1, SEED=0. Release reset with free_run=1 → lfsr_state is 0000, 0001, 0011, 0111, 1110, 1101, 1011, 0110, 1100, 1001 on successive cycles.
- Same config with OUT_BITS=4, RANGE=15, free_run=0. Pulse draw_req → draw_busy rises next cycle; draw_valid is a single pulse 6 cycles after the request edge with draw_value=14 and draw_fallback=0.
- Same config with RANGE=10, MAX_TRIES=2. Pulse draw_req → samples 14 then 12 are rejected; draw_valid fires with draw_value=2 and draw_fallback=1, 11 cycles after the request edge.
- XNOR=1, seed_load with seed_in=4'b1111 → state becomes 0000; seed_rejected pulses for exactly 1 cycle. seed_in=4'b0101 → state 0101, no pulse.
- seed_load asserted in the middle of SHIFT → FSM returns to IDLE, draw_valid never asserts. A draw_req raised during busy and held only while busy → no second draw starts.
- Assert reset during CHECK → all outputs 0 immediately (asynchronous), state=SEED, no draw_valid after release.

Source files
------------

// File: rtl/lfsr_draw_gen_if.sv
// ---------------------------------------------------------------------------
// lfsr_draw_gen_if
// Bundles the control and draw signals between the game FSM (master) and
// the LFSR draw engine (slave). clk and reset stay plain module ports.
//
// Signals:
//   free_run      master->slave  shift the LFSR every cycle while idle
//   seed_load     master->slave  load seed_in on the next edge (top priority)
//   seed_in       master->slave  seed value, WIDTH bits
//   draw_req      master->slave  start a draw; only honoured while idle
//   draw_busy     slave->master  engine is not idle
//   draw_valid    slave->master  one-cycle result pulse
//   draw_value    slave->master  result, OUT_BITS bits, held until next pulse
//   draw_fallback slave->master  result came from the fallback path
//   seed_rejected slave->master  one-cycle pulse: lock-state seed replaced
//   lfsr_state    slave->master  current LFSR state
//
// Handshake: draw_req is a request, not a queued command. It is sampled
// only on an edge where draw_busy is low; while draw_busy is high it is
// ignored. Every accepted request yields exactly one draw_valid pulse unless
// it is aborted by seed_load or reset, in which case no pulse is produced.
// There is no back-pressure: the master must capture draw_value (or simply
// read it later, since it is held) when draw_valid is high.
// ---------------------------------------------------------------------------
interface lfsr_draw_gen_if #(
    parameter int WIDTH    = 16,
    parameter int OUT_BITS = 4
) ();
    logic                free_run;
    logic                seed_load;
    logic [WIDTH-1:0]    seed_in;
    logic                draw_req;
    logic                draw_busy;
    logic                draw_valid;
    logic [OUT_BITS-1:0] draw_value;
    logic                draw_fallback;
    logic                seed_rejected;
    logic [WIDTH-1:0]    lfsr_state;

    modport master (
        output free_run, seed_load, seed_in, draw_req,
        input  draw_busy, draw_valid, draw_value, draw_fallback,
               seed_rejected, lfsr_state
    );

    modport slave (
        input  free_run, seed_load, seed_in, draw_req,
        output draw_busy, draw_valid, draw_value, draw_fallback,
               seed_rejected, lfsr_state
    );
endinterface

// File: rtl/lfsr_draw_gen.sv
// ---------------------------------------------------------------------------
// lfsr_draw_gen
// Fibonacci LFSR random source with a rejection-sampling draw engine.
// A draw shifts the LFSR OUT_BITS times, then inspects the low OUT_BITS of
// the state. Samples >= RANGE are rejected and the shift/inspect cycle is
// repeated; after MAX_TRIES rejections the last sample minus RANGE is
// returned and flagged as a fallback.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    lfsr_draw_gen_if.slave (request, seed and result signals)
// ---------------------------------------------------------------------------
module lfsr_draw_gen #(
    parameter int             WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'hB400,
    parameter bit             XNOR      = 1'b1,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int             OUT_BITS  = 4,
    parameter int             RANGE     = 10,
    parameter int             MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           reset,
    lfsr_draw_gen_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int SC_W = $clog2(OUT_BITS + 1);
    localparam int TC_W = $clog2(MAX_TRIES + 1);

    // The state that XOR/XNOR feedback can never leave.
    localparam logic [WIDTH-1:0]  LOCK    = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    // One extra bit so RANGE == 2^OUT_BITS is representable.
    localparam logic [OUT_BITS:0] RANGE_W = (OUT_BITS + 1)'(RANGE);

    logic [WIDTH-1:0]    state_q,     state_d;
    logic [1:0]          fsm_q,       fsm_d;
    logic [SC_W-1:0]     shift_cnt_q, shift_cnt_d;
    logic [TC_W-1:0]     try_cnt_q,   try_cnt_d;
    logic [OUT_BITS-1:0] value_q,     value_d;
    logic                fallback_q,  fallback_d;
    logic                seed_rej_q,  seed_rej_d;

    logic                fb;
    logic [WIDTH-1:0]    shifted;
    logic [OUT_BITS-1:0] sample;
    logic [TC_W-1:0]     try_inc;
    logic                accept;

    assign fb      = (^(state_q & TAPS)) ^ XNOR;
    assign shifted = {state_q[WIDTH-2:0], fb};
    assign sample  = state_q[OUT_BITS-1:0];
    assign accept  = ({1'b0, sample} < RANGE_W);
    assign try_inc = try_cnt_q + TC_W'(1);

    always_comb begin
        state_d     = state_q;
        fsm_d       = fsm_q;
        shift_cnt_d = shift_cnt_q;
        try_cnt_d   = try_cnt_q;
        value_d     = value_q;
        fallback_d  = fallback_q;
        seed_rej_d  = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (bus.draw_req) begin
                    fsm_d       = S_SHIFT;
                    shift_cnt_d = '0;
                    try_cnt_d   = '0;
                end else if (bus.free_run) begin
                    state_d = shifted;
                end
            end
            S_SHIFT: begin
                state_d = shifted;
                if (shift_cnt_q == SC_W'(OUT_BITS - 1)) begin
                    fsm_d = S_CHECK;
                end else begin
                    shift_cnt_d = shift_cnt_q + SC_W'(1);
                end
            end
            S_CHECK: begin
                if (accept) begin
                    value_d    = sample;
                    fallback_d = 1'b0;
                    fsm_d      = S_DONE;
                end else begin
                    try_cnt_d = try_inc;
                    if (try_inc == TC_W'(MAX_TRIES)) begin
                        // sample is in RANGE..2^OUT_BITS-1 here, and
                        // 2*RANGE >= 2^OUT_BITS keeps the difference < RANGE.
                        value_d    = sample - RANGE_W[OUT_BITS-1:0];
                        fallback_d = 1'b1;
                        fsm_d      = S_DONE;
                    end else begin
                        shift_cnt_d = '0;
                        fsm_d       = S_SHIFT;
                    end
                end
            end
            default: begin
                // S_DONE: draw_valid is high for exactly this one cycle.
                fsm_d = S_IDLE;
            end
        endcase

        // Reseeding overrides everything, including an in-flight draw.
        // A lock-state seed is replaced by SEED so the LFSR never sticks.
        if (bus.seed_load) begin
            if (bus.seed_in == LOCK) begin
                state_d    = SEED;
                seed_rej_d = 1'b1;
            end else begin
                state_d = bus.seed_in;
            end
            fsm_d       = S_IDLE;
            shift_cnt_d = '0;
            try_cnt_d   = '0;
            value_d     = value_q;
            fallback_d  = fallback_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEED;
            fsm_q       <= S_IDLE;
            shift_cnt_q <= '0;
            try_cnt_q   <= '0;
            value_q     <= '0;
            fallback_q  <= 1'b0;
            seed_rej_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fsm_q       <= fsm_d;
            shift_cnt_q <= shift_cnt_d;
            try_cnt_q   <= try_cnt_d;
            value_q     <= value_d;
            fallback_q  <= fallback_d;
            seed_rej_q  <= seed_rej_d;
        end
    end

    assign bus.draw_busy     = (fsm_q != S_IDLE);
    assign bus.draw_valid    = (fsm_q == S_DONE);
    assign bus.draw_value    = value_q;
    assign bus.draw_fallback = fallback_q;
    assign bus.seed_rejected = seed_rej_q;
    assign bus.lfsr_state    = state_q;

endmodule
